fib_mem_checker: RTL and testbench



---
 rtl/fib_mem_checker_if.sv | 21 ++
 rtl/fib_mem_checker.sv | 136 +++++++++++++
 tb/tb_fib_mem_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fib_mem_checker_if.sv
// Read-side RAM bus between the Fibonacci checker (master) and the data RAM (slave).
interface fib_mem_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rd_data
    );
endinterface

// File: rtl/fib_mem_checker.sv
// Sweeps the data RAM after the Fibonacci writer and checks every word against the
// recurrence built from the words actually read; reports pass, first bad address and count.
module fib_mem_checker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed0,
    input  logic [DATA_W-1:0]   seed1,
    fib_mem_checker_if.master   mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ADDR_W:0]     err_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W-1:0] r_err_addr;
    logic [ADDR_W:0]   r_err_count;
    logic              r_err_seen;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_idx;
    logic [DATA_W-1:0] r_h1;
    logic [DATA_W-1:0] r_h2;

    logic [DATA_W-1:0] w_expected;
    logic              w_mismatch;

    // History holds the words actually read, so one bad word also flags the two words after it.
    always_comb begin
        if (r_pend_idx == '0) begin
            w_expected = seed0;
        end else if (r_pend_idx == ADDR_W'(1)) begin
            w_expected = seed1;
        end else begin
            w_expected = r_h1 + r_h2;
        end
        w_mismatch = r_pend_vld && (mem.mem_rd_data != w_expected);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
            r_err_seen  <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_idx  <= '0;
            r_h1        <= '0;
            r_h2        <= '0;
        end else begin
            r_pend_vld <= r_mem_en;
            r_pend_idx <= r_mem_addr;

            if (r_pend_vld) begin
                r_h2 <= r_h1;
                r_h1 <= mem.mem_rd_data;
            end

            if (w_mismatch) begin
                r_err_count <= r_err_count + 1'b1;
                if (!r_err_seen) begin
                    r_err_seen <= 1'b1;
                    r_err_addr <= r_pend_idx;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= '0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_err_addr  <= '0;
                        r_err_seen  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_mem_addr == LAST_ADDR) begin
                        r_mem_en <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                // The last word is checked on the edge where the pending stage is still full.
                S_DRAIN: begin
                    if (!r_pend_vld) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_count == '0);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_en   = r_mem_en;
    assign mem.mem_addr = r_mem_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_addr     = r_err_addr;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_fib_mem_checker.sv
// Bench for fib_mem_checker: a 32-bit and an 8-bit instance (DEPTH=8) each with a
// registered-read RAM model, driven from a vector table plus hand-written corner sequences.
module tb_fib_mem_checker;

    typedef struct {
        bit               use8;
        logic [7:0][31:0] words;
        logic [31:0]      seed0;
        logic [31:0]      seed1;
        logic             expPass;
        logic [3:0]       expCnt;
        logic [2:0]       expAddr;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic sel8;
    logic [31:0] seed0;
    logic [31:0] seed1;

    logic [31:0] ram32 [8];
    logic [7:0]  ram8  [8];

    int checks;
    int errors;
    vec_t vecs [7];

    fib_mem_checker_if #(.DATA_W(32), .ADDR_W(3)) bus32 ();
    fib_mem_checker_if #(.DATA_W(8),  .ADDR_W(3)) bus8 ();

    logic busy32, done32, pass32, busy8, done8, pass8;
    logic [2:0] errAddr32, errAddr8;
    logic [3:0] errCnt32, errCnt8;
    logic start32, start8;

    assign start32 = start && !sel8;
    assign start8  = start && sel8;

    fib_mem_checker #(.DATA_W(32), .ADDR_W(3), .DEPTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32),
        .seed0(seed0), .seed1(seed1), .mem(bus32),
        .busy(busy32), .done(done32), .pass(pass32),
        .err_addr(errAddr32), .err_count(errCnt32)
    );

    fib_mem_checker #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .mem(bus8),
        .busy(busy8), .done(done8), .pass(pass8),
        .err_addr(errAddr8), .err_count(errCnt8)
    );

    always @(posedge clk) if (bus32.mem_en) bus32.mem_rd_data <= ram32[bus32.mem_addr];
    always @(posedge clk) if (bus8.mem_en)  bus8.mem_rd_data  <= ram8[bus8.mem_addr];

    logic       curEn, curBusy, curDone, curPass;
    logic [2:0] curAddr, curErrAddr;
    logic [3:0] curCnt;

    always_comb begin
        if (sel8) begin
            curEn = bus8.mem_en;   curAddr = bus8.mem_addr;   curBusy = busy8;
            curDone = done8;       curPass = pass8;           curErrAddr = errAddr8;
            curCnt = errCnt8;
        end else begin
            curEn = bus32.mem_en;  curAddr = bus32.mem_addr;  curBusy = busy32;
            curDone = done32;      curPass = pass32;          curErrAddr = errAddr32;
            curCnt = errCnt32;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic setVec(input int idx, input bit u8,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                          input logic [31:0] w6, input logic [31:0] w7,
                          input logic [31:0] s0, input logic [31:0] s1,
                          input logic p, input logic [3:0] c, input logic [2:0] a);
        vecs[idx].use8    = u8;
        vecs[idx].words   = {w7, w6, w5, w4, w3, w2, w1, w0};
        vecs[idx].seed0   = s0;
        vecs[idx].seed1   = s1;
        vecs[idx].expPass = p;
        vecs[idx].expCnt  = c;
        vecs[idx].expAddr = a;
    endtask

    task automatic loadVec(input int vi);
        sel8  = vecs[vi].use8;
        seed0 = vecs[vi].seed0;
        seed1 = vecs[vi].seed1;
        for (int i = 0; i < 8; i++) begin
            ram32[i] = vecs[vi].words[i];
            ram8[i]  = vecs[vi].words[i][7:0];
        end
    endtask

    // Runs one full sweep from a start pulse; repulseAt > 0 re-asserts start so it is sampled at that edge.
    task automatic applyStimulus(input int vi, input int repulseAt);
        int edges;
        bit seen;
        string tag;
        tag = $sformatf("v%0d", vi);
        loadVec(vi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, ".acceptBusy"}, curBusy, 1);
        checkOutput({tag, ".acceptEn"}, curEn, 1);
        checkOutput({tag, ".acceptAddr"}, curAddr, 0);
        checkOutput({tag, ".acceptCnt"}, curCnt, 0);
        checkOutput({tag, ".acceptPass"}, curPass, 0);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 40) begin
            if (edges + 1 == repulseAt) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            if (edges <= 7) checkOutput($sformatf("%s.addr%0d", tag, edges), curAddr, edges);
            if (curDone) seen = 1;
        end
        checkOutput({tag, ".doneEdge"}, edges, 10);
        checkOutput({tag, ".pass"}, curPass, vecs[vi].expPass);
        checkOutput({tag, ".errCount"}, curCnt, vecs[vi].expCnt);
        checkOutput({tag, ".errAddr"}, curErrAddr, vecs[vi].expAddr);
        checkOutput({tag, ".busyAtDone"}, curBusy, 0);
        checkOutput({tag, ".enAtDone"}, curEn, 0);
        @(posedge clk); #1;
        checkOutput({tag, ".donePulse"}, curDone, 0);
        checkOutput({tag, ".passHeld"}, curPass, vecs[vi].expPass);
        checkOutput({tag, ".cntHeld"}, curCnt, vecs[vi].expCnt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sel8   = 1'b0;
        seed0  = '0;
        seed1  = '0;
        for (int i = 0; i < 8; i++) begin
            ram32[i] = '0;
            ram8[i]  = '0;
        end

        //        idx u8 w0            w1 w2 w3 w4 w5 w6 w7  seed0         seed1 pass cnt addr
        setVec(0, 0, 1,            1, 2, 3, 5, 8, 13, 21, 1,            1,   1,   0,  0);
        setVec(1, 0, 1,            1, 2, 3, 5, 9, 13, 21, 1,            1,   0,   3,  5);
        setVec(2, 0, 1,            1, 2, 3, 5, 8, 13, 21, 2,            1,   0,   1,  0);
        setVec(3, 0, 1,            7, 2, 3, 5, 8, 13, 21, 1,            1,   0,   3,  1);
        setVec(4, 0, 1,            1, 2, 3, 5, 8, 13, 22, 1,            1,   0,   1,  7);
        setVec(5, 1, 200,        100, 44, 144, 188, 76, 8, 84, 200,   100,   1,   0,  0);
        setVec(6, 0, 32'hFFFFFFFF, 2, 1, 3, 4, 7, 11, 18, 32'hFFFFFFFF, 2,   1,   0,  0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.en", bus32.mem_en, 0);
        checkOutput("reset.addr", bus32.mem_addr, 0);
        checkOutput("reset.busy", busy32, 0);
        checkOutput("reset.done", done32, 0);
        checkOutput("reset.pass", pass32, 0);
        checkOutput("reset.errAddr", errAddr32, 0);
        checkOutput("reset.errCount", errCnt32, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) applyStimulus(v, -1);

        // start sampled at E3 mid-sweep must not disturb it; then back-to-back sweeps clear results
        applyStimulus(0, 3);
        applyStimulus(1, -1);
        applyStimulus(0, -1);

        // asynchronous reset in the middle of an erroring sweep
        loadVec(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("preReset.addr", bus32.mem_addr, 4);
        checkOutput("preReset.errCount", errCnt32, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.en", bus32.mem_en, 0);
        checkOutput("midReset.addr", bus32.mem_addr, 0);
        checkOutput("midReset.busy", busy32, 0);
        checkOutput("midReset.errCount", errCnt32, 0);
        checkOutput("midReset.errAddr", errAddr32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
